// File: rtl/mem_arbiter.sv
// Two-port (fetch / data) round-robin arbiter in front of a shared, synchronous-read memory slice.
// Each granted request runs to completion before the next grant is made.
module mem_arbiter #(
    parameter int unsigned ADDR_W = 11
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              i_req,
    input  logic [ADDR_W-1:0] i_addr,
    output logic              i_ack,
    output logic [31:0]       i_rdata,
    output logic              i_err,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [1:0]        d_width,
    input  logic              d_signed,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [31:0]       d_wdata,
    output logic              d_ack,
    output logic [31:0]       d_rdata,
    output logic              d_err,
    output logic              m_ren,
    output logic              m_wen,
    output logic [1:0]        m_width_mode,
    output logic              m_signed_mode,
    output logic [ADDR_W-1:0] m_addr,
    output logic [31:0]       m_wdata,
    input  logic [31:0]       m_rdata,
    output logic              busy
);

    typedef enum logic [2:0] {StIdle, StRdAddr, StRdData, StWr, StErr} state_e;

    state_e              state_q, state_d;
    logic                grant_q;       // 1 = data port owns the current transaction
    logic                last_grant_q;  // 1 = data port was granted last
    logic [ADDR_W-1:0]   addr_q;
    logic [1:0]          width_q;
    logic                signed_q;
    logic [31:0]         wdata_q;
    logic                i_ack_q, d_ack_q, i_err_q, d_err_q;
    logic [31:0]         i_rdata_q, d_rdata_q;

    logic                i_pend, d_pend, pick_d, start, sel_fault;
    logic [ADDR_W-1:0]   sel_addr;
    logic [1:0]          sel_width;
    logic                sel_signed, sel_we;

    // A port whose ack is showing this cycle is not yet eligible again.
    assign i_pend = i_req & ~i_ack_q;
    assign d_pend = d_req & ~d_ack_q;
    assign pick_d = d_pend & (~i_pend | ~last_grant_q);
    assign start  = (state_q == StIdle) & (i_pend | d_pend);

    always_comb begin
        sel_addr   = pick_d ? d_addr : i_addr;
        sel_width  = pick_d ? d_width : 2'b00;
        sel_signed = pick_d & d_signed;
        sel_we     = pick_d & d_we;
        sel_fault  = (sel_width == 2'b11) ||
                     ((sel_width == 2'b00) && (sel_addr[1:0] != 2'b00)) ||
                     ((sel_width == 2'b01) && (sel_addr[1:0] == 2'b11));
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: begin
                if (start) begin
                    if (sel_fault)   state_d = StErr;
                    else if (sel_we) state_d = StWr;
                    else             state_d = StRdAddr;
                end
            end
            StRdAddr: state_d = StRdData;
            StRdData: state_d = StIdle;
            StWr:     state_d = StIdle;
            StErr:    state_d = StIdle;
            default:  state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= StIdle;
            grant_q      <= 1'b0;
            last_grant_q <= 1'b1;
            addr_q       <= '0;
            width_q      <= 2'b00;
            signed_q     <= 1'b0;
            wdata_q      <= '0;
            i_ack_q      <= 1'b0;
            d_ack_q      <= 1'b0;
            i_err_q      <= 1'b0;
            d_err_q      <= 1'b0;
            i_rdata_q    <= '0;
            d_rdata_q    <= '0;
        end else begin
            state_q <= state_d;
            if (start) begin
                grant_q      <= pick_d;
                last_grant_q <= pick_d;
                addr_q       <= sel_addr;
                width_q      <= sel_width;
                signed_q     <= sel_signed;
                wdata_q      <= pick_d ? d_wdata : 32'h0;
            end
            i_ack_q <= 1'b0;
            d_ack_q <= 1'b0;
            i_err_q <= 1'b0;
            d_err_q <= 1'b0;
            if (state_q == StRdData || state_q == StWr || state_q == StErr) begin
                i_ack_q <= ~grant_q;
                d_ack_q <= grant_q;
                i_err_q <= ~grant_q & (state_q == StErr);
                d_err_q <= grant_q & (state_q == StErr);
            end
            if (state_q == StRdData) begin
                if (grant_q) d_rdata_q <= m_rdata;
                else         i_rdata_q <= m_rdata;
            end
        end
    end

    // Slice controls are pure decodes of the state so reset clears them without a clock.
    always_comb begin
        m_ren         = (state_q == StRdAddr) || (state_q == StRdData);
        m_wen         = (state_q == StWr);
        m_addr        = (m_ren || m_wen) ? addr_q : '0;
        m_width_mode  = (m_ren || m_wen) ? width_q : 2'b00;
        m_signed_mode = m_ren ? signed_q : 1'b0;
        m_wdata       = m_wen ? wdata_q : 32'h0;
        busy          = (state_q != StIdle);
    end

    assign i_ack   = i_ack_q;
    assign d_ack   = d_ack_q;
    assign i_err   = i_err_q;
    assign d_err   = d_err_q;
    assign i_rdata = i_rdata_q;
    assign d_rdata = d_rdata_q;

endmodule
